// File: rtl/muller_c_proj_pkg.sv
// muller_c_proj_pkg: shared defaults, io_in/evt_cnt slicing helpers and the C-element hold/set/clear rule
package muller_c_proj_pkg;
  localparam int N_CH_DEF = 3;
  localparam int CNT_W_DEF = 8;
  function automatic int a_bit(int k);
    return 2 * k + 1;
  endfunction
  function automatic int b_bit(int k);
    return 2 * k;
  endfunction
  function automatic int cnt_lsb(int k, int w);
    return k * w;
  endfunction
  function automatic logic c_rule(logic a, logic b, logic c);
    return (a & b) | (c & (a | b));
  endfunction
endpackage

// File: rtl/c_element.sv
// c_element: registered 2-input Muller C-element; ports clk, rst (async high), a, b -> c
module c_element
  import muller_c_proj_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic c
);
  logic c_q, c_d;
  assign c_d = c_rule(a, b, c_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) c_q <= 1'b0;
    else c_q <= c_d;
  assign c = c_q;
endmodule

// File: rtl/muller_c_proj_formal.sv
// muller_c_proj_formal: formal harness exposing only io_in; clock from the global clock, reset for the first steps (FORMAL builds only)
`ifdef FORMAL
module muller_c_proj_formal
  import muller_c_proj_pkg::*;
(
  input logic [2*N_CH_DEF-1:0] io_in
);
  (* gclk *) logic gclk;
  logic clk_q, rst;
  logic [1:0] age_q;
  logic [N_CH_DEF-1:0] c_out;
  logic c_all;
  logic [N_CH_DEF*CNT_W_DEF-1:0] evt_cnt;
  always_ff @(posedge gclk) clk_q <= ~clk_q;
  always_ff @(posedge clk_q) age_q <= age_q + 2'(age_q != 2'd3);
  assign rst = age_q != 2'd3;
  muller_c_proj u_dut (
    .wb_clk_i(clk_q),
    .wb_rst_i(rst),
    .io_in   (io_in),
    .c_out   (c_out),
    .c_all   (c_all),
    .evt_cnt (evt_cnt)
  );
  always_comb begin
    if (rst) assert (c_out == '0 && !c_all && evt_cnt == '0);
    cover (c_all);
    cover (evt_cnt[CNT_W_DEF-1:0] == '1);
  end
endmodule
`endif

// File: rtl/muller_c_proj.sv
// muller_c_proj: N_CH registered C-elements, an all-channel C-element c_all and per-channel transition counters
// Ports: wb_clk_i, wb_rst_i (async high), io_in[2*N_CH] (a=2k+1,b=2k), c_out[N_CH], c_all, evt_cnt[N_CH*CNT_W]
// MULLER_C_SYNC_EN: adds a 2-flop synchronizer on io_in (3-cycle latency instead of 1)
module muller_c_proj
  import muller_c_proj_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [2*N_CH-1:0]     io_in,
  output logic [N_CH-1:0]       c_out,
  output logic                  c_all,
  output logic [N_CH*CNT_W-1:0] evt_cnt
);
  logic [2*N_CH-1:0] eval_in;
`ifdef MULLER_C_SYNC_EN
  logic [2*N_CH-1:0] sync1_q, sync2_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  assign eval_in = sync2_q;
`else
  assign eval_in = io_in;
`endif
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    c_element u_c (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .a  (eval_in[a_bit(k)]),
      .b  (eval_in[b_bit(k)]),
      .c  (c_out[k])
    );
    // count on the same edge c_out changes, using the element's next-state rule
    assign cnt_d = cnt_q + CNT_W'(c_rule(eval_in[a_bit(k)], eval_in[b_bit(k)], c_out[k]) != c_out[k]);
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
    assign evt_cnt[cnt_lsb(k, CNT_W) +: CNT_W] = cnt_q;
  end
  logic c_all_q, c_all_d;
  assign c_all_d = &c_out ? 1'b1 : (|c_out ? c_all_q : 1'b0);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) c_all_q <= 1'b0;
    else c_all_q <= c_all_d;
  assign c_all = c_all_q;
endmodule

// File: tb/tb_muller_c_proj.sv
// tb_muller_c_proj: scoreboard bench for muller_c_proj (works with or without MULLER_C_SYNC_EN)
module tb_muller_c_proj;
`ifdef MULLER_C_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  typedef struct {
    logic [2:0]  c;
    logic        ca;
    logic [23:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] io_in = '0;
  logic [2:0] c_out;
  logic c_all;
  logic [23:0] evt_cnt;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [2:0] m_c;
  logic m_call;
  logic [7:0] m_cnt[3];
  logic [5:0] m_s1, m_s2;
  muller_c_proj u_dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .io_in   (io_in),
    .c_out   (c_out),
    .c_all   (c_all),
    .evt_cnt (evt_cnt)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_c = '0;
    m_call = 1'b0;
    for (int k = 0; k < 3; k++) m_cnt[k] = '0;
    m_s1 = '0;
    m_s2 = '0;
    q.delete();
  endtask
  task automatic cyc(input logic [5:0] v);
    logic [5:0] eff;
    logic [2:0] nc;
    exp_t e;
    io_in = v;
    @(posedge clk);
    eff = (LAT == 1) ? v : m_s2;
    m_s2 = m_s1;
    m_s1 = v;
    for (int k = 0; k < 3; k++) begin
      if (eff[2*k+1] && eff[2*k]) nc[k] = 1'b1;
      else if (!eff[2*k+1] && !eff[2*k]) nc[k] = 1'b0;
      else nc[k] = m_c[k];
      if (nc[k] != m_c[k]) m_cnt[k] = m_cnt[k] + 8'd1;
    end
    if (m_c == 3'b111) m_call = 1'b1;
    else if (m_c == 3'b000) m_call = 1'b0;
    m_c = nc;
    e.c = m_c;
    e.ca = m_call;
    e.cnt = {m_cnt[2], m_cnt[1], m_cnt[0]};
    q.push_back(e);
    #1;
    e = q.pop_front();
    checks++;
    if (c_out !== e.c) begin
      errors++;
      $display("FAIL c_out io_in=%b got=%b exp=%b", v, c_out, e.c);
    end
    checks++;
    if (c_all !== e.ca) begin
      errors++;
      $display("FAIL c_all io_in=%b got=%b exp=%b", v, c_all, e.ca);
    end
    checks++;
    if (evt_cnt !== e.cnt) begin
      errors++;
      $display("FAIL evt_cnt io_in=%b got=%h exp=%h", v, evt_cnt, e.cnt);
    end
  endtask
  task automatic check_zero(input string nm);
    checks++;
    if (c_out !== 3'b000 || c_all !== 1'b0 || evt_cnt !== 24'h0) begin
      errors++;
      $display("FAIL %s got c_out=%b c_all=%b evt_cnt=%h exp all zero", nm, c_out, c_all, evt_cnt);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_basic();
    for (int i = 0; i < LAT + 1; i++) cyc(6'b011110);
    checks++;
    if (c_out !== 3'b010) begin
      errors++;
      $display("FAIL basic_c_out got=%b exp=010", c_out);
    end
    checks++;
    if (evt_cnt !== 24'h000100) begin
      errors++;
      $display("FAIL basic_evt_cnt got=%h exp=000100", evt_cnt);
    end
  endtask
  task automatic test_hold();
    for (int i = 0; i < LAT; i++) cyc(6'b111111);
    checks++;
    if (c_out !== 3'b111 || c_all !== 1'b0) begin
      errors++;
      $display("FAIL all_set got c_out=%b c_all=%b exp 111/0", c_out, c_all);
    end
    cyc(6'b111111);
    checks++;
    if (c_all !== 1'b1) begin
      errors++;
      $display("FAIL c_all_rise got=%b exp=1", c_all);
    end
    for (int i = 0; i < LAT + 2; i++) cyc(6'b100110);
    checks++;
    if (c_out !== 3'b111) begin
      errors++;
      $display("FAIL hold_mixed got=%b exp=111", c_out);
    end
  endtask
  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 128; i++) begin
      cyc(6'b000011);
      cyc(6'b000000);
    end
    for (int i = 0; i < LAT - 1; i++) cyc(6'b000000);
    checks++;
    if (evt_cnt[7:0] !== 8'h00 || c_out !== 3'b000) begin
      errors++;
      $display("FAIL wrap got cnt0=%h c_out=%b exp 00/000", evt_cnt[7:0], c_out);
    end
  endtask
  task automatic test_latency();
    int seen;
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 1; i <= 8 && seen == 0; i++) begin
      cyc(6'b000011);
      if (c_out[0] === 1'b1) seen = i;
    end
    checks++;
    if (seen != LAT) begin
      errors++;
      $display("FAIL latency got=%0d cycles exp=%0d (0 = never rose)", seen, LAT);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1000; i++) cyc(6'($urandom));
  endtask
  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_hold();
    test_async_reset();
    test_wrap();
    test_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muller_c_proj.md
MULLER_C_PROJ -- requirements
Module: muller_c_proj

Interface
REQ-001 Parameter N_CH, default 3: number of 2-input C-element channels; io_in width = 2*N_CH.
REQ-002 Parameter CNT_W, default 8: width of each channel's output-transition counter.
REQ-003 wb_clk_i  input  1  sole clock; all state on its rising edge.
REQ-004 wb_rst_i  input  1  reset; asynchronous and active-high.
REQ-005 io_in  input  2*N_CH  channel k operands: a = io_in[2k+1], b = io_in[2k].
REQ-006 c_out  output  N_CH  registered C-element output per channel.
REQ-007 c_all  output  1  registered C-element over all c_out bits.
REQ-008 evt_cnt  output  N_CH*CNT_W  per-channel transition counters; channel k in bits [k*CNT_W +: CNT_W].

Function
REQ-009 Per channel, the next state SHALL be: 1 if a=b=1; 0 if a=b=0; hold the current c_out if a!=b.
REQ-010 c_out SHALL update on the clock edge after the effective inputs are sampled; latency is 1 cycle without synchronizer and 3 cycles with it.
REQ-011 c_all SHALL be 1 when all c_out bits are 1, 0 when all are 0, and hold otherwise; it updates 1 cycle after c_out.
REQ-012 evt_cnt[k] SHALL increment by 1 on every cycle in which c_out[k] changes value, in either direction.
REQ-013 evt_cnt[k] SHALL wrap from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-014 Channels SHALL be fully independent; simultaneous changes on several channels SHALL update each channel in the same cycle.
REQ-015 Input changes with a!=b SHALL never alter state, whatever their order or glitching between edges.

Reset
REQ-016 Asserting wb_rst_i SHALL immediately force c_out=0, c_all=0, evt_cnt=0 and all synchronizer flops to 0, without waiting for a clock edge.
REQ-017 On deassertion, the first evaluation SHALL occur at the next rising edge; reset mid-operation discards all held state.
REQ-018 Reset forcing c_out to 0 SHALL NOT count as a transition.

Configuration
REQ-019 Macro MULLER_C_SYNC_EN: when defined, io_in SHALL pass through a 2-flop synchronizer per bit before evaluation (3-cycle latency); when undefined, io_in SHALL feed evaluation directly (1-cycle latency).

Structure
REQ-020 A shared package SHALL hold the default N_CH and CNT_W constants and the channel-index helper for slicing io_in and evt_cnt.
REQ-021 One sub-module, c_element (inputs a, b; clock; reset; registered output c), SHALL be instantiated N_CH times; the c_all stage SHALL be an N-input variant of the same hold/set/clear rule.
REQ-022 A formal wrapper muller_c_proj_formal SHALL expose only io_in, with clock and reset driven internally, for cover and assert runs.

Verification
REQ-023 Reset, then io_in=6'b011110 held 2 cycles (no sync) -> c_out=3'b010, c_all=0, evt_cnt ch1=1, ch0=ch2=0.
REQ-024 io_in=6'b111111 -> c_out=3'b111 after 1 cycle, c_all=1 one cycle later; then io_in=6'b100110 -> c_out stays 3'b111.
REQ-025 Toggle io_in[1:0] 11->00->11 repeatedly 256 times with CNT_W=8 -> evt_cnt ch0 wraps to 0.
REQ-026 Assert wb_rst_i between clock edges while c_out=3'b111 -> all outputs 0 immediately, evt_cnt=0.
REQ-027 With MULLER_C_SYNC_EN, io_in=6'b000011 after reset -> c_out[0] rises exactly 3 cycles later.
REQ-028 Random io_in for 1000 cycles -> c_out matches a reference hold/set/clear model every cycle.
